seq_div: RTL and testbench
==========================

Name: seq_div

Overview:
- Sequential restoring divider, the inverse companion to the shift-add sequential multiplier.
- Divides a 2W-bit dividend (multiplier product width) by a W-bit divisor, one quotient bit per clock.
- Controller and datapath in one block, with a start/done handshake.
- Used by the arithmetic unit to undo or scale products and to return quotient and remainder.

Parameters:
- W, 24, divisor/quotient/remainder width; dividend is 2W bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- DividendBus  input  2W  dividend, captured on accepting edge
- Bbus  input  W  divisor, captured on accepting edge
- Quotient  output  W  quotient register
- Remainder  output  W  remainder register
- busy  output  1  high while not IDLE
- done  output  1  one-cycle completion pulse
- div_by_zero  output  1  error flag, valid with done
- overflow  output  1  quotient does not fit in W bits, valid with done

Behaviour:
- Reset, async, any state including mid-operation:
  - state IDLE; Preg, Areg, Breg, counter = 0.
  - Quotient = Remainder = 0; busy = done = div_by_zero = overflow = 0.
- Registers:
  - Preg (W), partial remainder.
  - Areg (W), dividend low half, becomes quotient.
  - Breg (W), divisor.
  - cnt, $clog2(W) bits.
- States: IDLE, CALC, DONE.
- IDLE, accepting edge E0 when start=1:
  - Breg <= Bbus; Preg <= DividendBus[2W-1:W]; Areg <= DividendBus[W-1:0].
  - Clear both error flags.
  - If Bbus==0: set div_by_zero, go to DONE.
  - Else if DividendBus[2W-1:W] >= Bbus: set overflow, go to DONE.
  - Else: cnt <= 0, go to CALC.
- CALC, each edge:
  - T = {Preg, Areg[W-1]} − {1'b0, Breg}, computed at W+1 bits.
  - If T non-negative (T[W]==0): Preg <= T[W-1:0]; Areg <= {Areg[W-2:0], 1'b1}.
  - Else: Preg <= {Preg[W-2:0], Areg[W-1]}; Areg <= {Areg[W-2:0], 1'b0}.
  - The shifted-out bit must keep its W+1 width in the compare; no truncation.
  - cnt increments; on the edge with cnt==W-1, go to DONE.
- Latency:
  - Normal path: done is high in the cycle after edge E_W, i.e. W edges after E0.
  - Error path: done is high in the cycle after E0.
- DONE:
  - done=1 for exactly one cycle; next edge goes to IDLE.
  - Normal path: Quotient = Areg, Remainder = Preg.
  - Error path: Quotient = {W{1'b1}}, Remainder = 0.
  - Quotient, Remainder and flags hold until the next accepted start.
- busy = (state != IDLE). start while busy is ignored; no queuing.
- start held high continuously: a new operation is accepted on the first IDLE edge, i.e. the edge after DONE.
- Changes to DividendBus or Bbus after E0 have no effect.

Optional Feature:
- Macro: SEQ_DIV_SIGNED_EN.
- Defined:
  - Operands are two's complement.
  - At E0, absolute values are latched; signs are saved as qneg = sign(dividend) XOR sign(divisor) and rneg = sign(dividend).
  - Overflow check is on magnitudes and also flags a magnitude quotient > 2^(W-1)−1, or > 2^(W-1) when qneg.
  - An extra FIX state between CALC and DONE negates the quotient if qneg and the remainder if rneg.
  - Normal latency becomes W+1 edges.
  - Remainder sign follows the dividend; quotient truncates toward zero.
- Undefined: unsigned only; no FIX state; latency W edges.

Test Plan:
- W=24, DividendBus=0x000000BC614E (12345678), Bbus=1000, start 1 cycle -> done after 24 edges past E0; Quotient=0x003039, Remainder=0x0002A6, flags 0, busy high for exactly 25 cycles.
- DividendBus=0xFFFFFE000001, Bbus=0xFFFFFF -> Quotient=0xFFFFFF, Remainder=0, overflow=0 (max-range case).
- Bbus=0, any dividend -> done in the cycle after E0; div_by_zero=1, Quotient=0xFFFFFF, Remainder=0. Then DividendBus=0x10000000, Bbus=0x10 -> overflow=1, div_by_zero=0.
- Start 100/7, pulse start again at cycle 5 with other operands -> pulse ignored, result Quotient=14, Remainder=2. Then assert rst at cycle 10 of a new 100/7 -> all outputs 0 immediately, state IDLE; next start completes normally.
- SEQ_DIV_SIGNED_EN defined, dividend −100 (0xFFFFFFFFFF9C), Bbus=7 -> Quotient=0xFFFFF2 (−14), Remainder=0xFFFFFE (−2), done after 25 edges past E0.

Source files
------------

// File: rtl/seq_div.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per clock.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (adds a FIX state for sign correction).
module seq_div #(
    parameter int W = 24
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*W-1:0] DividendBus,
    input  logic [W-1:0]   Bbus,
    output logic [W-1:0]   Quotient,
    output logic [W-1:0]   Remainder,
    output logic           busy,
    output logic           done,
    output logic           div_by_zero,
    output logic           overflow
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  preg_q, preg_d;
    logic [W-1:0]  areg_q, areg_d;
    logic [W-1:0]  breg_q, breg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  rem_q, rem_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;

    logic [2*W-1:0] dvd_mag;
    logic [W-1:0]   dvs_mag;
    logic           range_err;
    logic [W:0]     diff;

`ifdef SEQ_DIV_SIGNED_EN
    logic           qneg_q, qneg_d;
    logic           rneg_q, rneg_d;
    logic           qneg_in;
    logic [2*W-1:0] q_limit;

    // Smallest magnitude dividend whose quotient no longer fits the signed result range.
    always_comb begin
        dvd_mag   = DividendBus[2*W-1] ? -DividendBus : DividendBus;
        dvs_mag   = Bbus[W-1] ? -Bbus : Bbus;
        qneg_in   = DividendBus[2*W-1] ^ Bbus[W-1];
        q_limit   = ({{W{1'b0}}, dvs_mag} << (W - 1))
                  + (qneg_in ? {{W{1'b0}}, dvs_mag} : '0);
        range_err = (dvd_mag >= q_limit);
    end
`else
    assign dvd_mag   = DividendBus;
    assign dvs_mag   = Bbus;
    assign range_err = 1'b0;
`endif

    assign diff = {preg_q, areg_q[W-1]} - {1'b0, breg_q};

    always_comb begin
        state_d = state_q;
        preg_d  = preg_q;
        areg_d  = areg_q;
        breg_d  = breg_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
`ifdef SEQ_DIV_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    breg_d = dvs_mag;
                    preg_d = dvd_mag[2*W-1:W];
                    areg_d = dvd_mag[W-1:0];
                    dbz_d  = 1'b0;
                    ovf_d  = 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
                    qneg_d = qneg_in;
                    rneg_d = DividendBus[2*W-1];
`endif
                    if (Bbus == '0 || dvd_mag[2*W-1:W] >= dvs_mag || range_err) begin
                        dbz_d   = (Bbus == '0);
                        ovf_d   = (Bbus != '0);
                        quo_d   = '1;
                        rem_d   = '0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (!diff[W]) begin
                    preg_d = diff[W-1:0];
                    areg_d = {areg_q[W-2:0], 1'b1};
                end else begin
                    preg_d = {preg_q[W-2:0], areg_q[W-1]};
                    areg_d = {areg_q[W-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
`ifdef SEQ_DIV_SIGNED_EN
                    state_d = FIX;
`else
                    quo_d   = areg_d;
                    rem_d   = preg_d;
                    done_d  = 1'b1;
                    state_d = DONE;
`endif
                end
            end
`ifdef SEQ_DIV_SIGNED_EN
            FIX: begin
                areg_d  = qneg_q ? -areg_q : areg_q;
                preg_d  = rneg_q ? -preg_q : preg_q;
                quo_d   = areg_d;
                rem_d   = preg_d;
                done_d  = 1'b1;
                state_d = DONE;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            preg_q  <= '0;
            areg_q  <= '0;
            breg_q  <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            preg_q  <= preg_d;
            areg_q  <= areg_d;
            breg_q  <= breg_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
`ifdef SEQ_DIV_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign Quotient    = quo_q;
    assign Remainder   = rem_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div: randomized and directed divisions against an arithmetic reference model.
// Handshake: an operation is accepted on the rising edge where start=1 and the divider is idle.
`timescale 1ns/1ps
module tb_seq_div;
    localparam int W = 24;
`ifdef SEQ_DIV_SIGNED_EN
    localparam int NORM_LAT = W + 1;
`else
    localparam int NORM_LAT = W;
`endif
    localparam int TIMEOUT = 200;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [2*W-1:0] dividend_bus = '0;
    logic [W-1:0]   bbus = '0;
    logic [W-1:0]   quotient, remainder;
    logic           busy, done, div_by_zero, overflow;

    // Expected entries: {quotient, remainder, div_by_zero, overflow}
    logic [2*W+1:0] exp_q[$];
    int total = 0;
    int passed = 0;

    seq_div #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .DividendBus(dividend_bus), .Bbus(bbus),
        .Quotient(quotient), .Remainder(remainder),
        .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    function automatic logic [2*W+1:0] ref_div(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
        logic [W-1:0] ones;
        logic [W-1:0] zeros;
`ifdef SEQ_DIV_SIGNED_EN
        longint a, b, q, r, half;
`else
        longint unsigned a, b;
`endif
        ones  = '1;
        zeros = '0;
`ifdef SEQ_DIV_SIGNED_EN
        a    = $signed(dvd);
        b    = $signed(dvs);
        half = longint'(1) << (W - 1);
        if (b == 0) return {ones, zeros, 2'b10};
        q = a / b;
        r = a % b;
        if (q > half - 1 || q < -half) return {ones, zeros, 2'b01};
        return {q[W-1:0], r[W-1:0], 2'b00};
`else
        a = dvd;
        b = dvs;
        if (b == 0) return {ones, zeros, 2'b10};
        if ((a >> W) >= b) return {ones, zeros, 2'b01};
        return {W'(a / b), W'(a % b), 2'b00};
`endif
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [2*W+1:0] e;
        if (!rst && done) begin
            check("done_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("quotient", quotient, e[2*W+1:W+2]);
                check("remainder", remainder, e[W+1:2]);
                check("div_by_zero", div_by_zero, e[1]);
                check("overflow", overflow, e[0]);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", busy, 0);
    endtask

    task automatic run_op(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs, input bit pulse_mid);
        logic [2*W+1:0] e;
        int edges, busy_cycles, lat;
        e   = ref_div(dvd, dvs);
        lat = (e[1] | e[0]) ? 0 : NORM_LAT;
        wait_idle();
        @(negedge clk);
        dividend_bus = dvd;
        bbus         = dvs;
        start        = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start        = 1'b0;
        dividend_bus = 48'({$urandom, $urandom});
        bbus         = W'($urandom);
        edges        = -1;
        busy_cycles  = 0;
        do begin
            @(negedge clk);
            edges++;
            if (busy) busy_cycles++;
            if (pulse_mid && edges == 4) begin
                start        = 1'b1;
                dividend_bus = 48'({$urandom, $urandom});
                bbus         = W'($urandom);
            end else begin
                start = 1'b0;
            end
        end while (!done && edges < TIMEOUT);
        start = 1'b0;
        if (!done) begin
            check("done_timeout", done, 1);
            return;
        end
        check("latency", edges, lat);
        check("busy_cycles", busy_cycles, lat + 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
    endtask

    task automatic reset_mid(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
        wait_idle();
        @(negedge clk);
        dividend_bus = dvd;
        bbus         = dvs;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_quotient", quotient, 0);
        check("rst_mid_remainder", remainder, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_flags", {div_by_zero, overflow}, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic held_start(input logic [2*W-1:0] dvd_a, input logic [W-1:0] dvs_a,
                              input logic [2*W-1:0] dvd_b, input logic [W-1:0] dvs_b);
        logic [2*W+1:0] eb;
        int n;
        eb = ref_div(dvd_b, dvs_b);
        wait_idle();
        @(negedge clk);
        dividend_bus = dvd_a;
        bbus         = dvs_a;
        start        = 1'b1;
        exp_q.push_back(ref_div(dvd_a, dvs_a));
        exp_q.push_back(eb);
        @(posedge clk);
        #1;
        dividend_bus = dvd_b;
        bbus         = dvs_b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < TIMEOUT);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < TIMEOUT);
        start = 1'b0;
        check("held_start_gap", n, 2 + ((eb[1] | eb[0]) ? 0 : NORM_LAT));
        @(negedge clk);
    endtask

    task automatic rand_operands(output logic [2*W-1:0] dvd, output logic [W-1:0] dvs);
        logic [W-1:0] hi;
        logic [31:0]  s;
        dvs = W'($urandom);
        case ($urandom_range(3))
            0: dvd = 48'({$urandom, $urandom});
            1: begin
                hi  = (dvs == '0) ? '0 : W'($urandom_range(32'(dvs) - 1));
                dvd = {hi, W'($urandom)};
            end
            2: begin
                s   = $urandom;
                dvd = {{(2*W-32){s[31]}}, s};
            end
            default: begin
                dvs = W'($urandom_range(255));
                dvd = 48'({$urandom, $urandom}) >> $urandom_range(47);
            end
        endcase
    endtask

    initial begin
        logic [2*W-1:0] d;
        logic [W-1:0]   b;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_div_by_zero", div_by_zero, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b0;

        run_op(48'h0000_00BC_614E, 24'd1000, 1'b0);
        run_op(48'hFFFF_FE00_0001, 24'hFFFFFF, 1'b0);
        run_op(48'({$urandom, $urandom}), 24'h0, 1'b0);
        run_op(48'h0000_1000_0000, 24'h10, 1'b0);
        run_op(48'd100, 24'd7, 1'b1);
        reset_mid(48'd100, 24'd7);
        run_op(48'd100, 24'd7, 1'b0);
        run_op(48'hFFFF_FFFF_FF9C, 24'd7, 1'b0);
        held_start(48'd12345, 24'd99, 48'd100000, 24'd3);

        for (int i = 0; i < 40; i++) begin
            rand_operands(d, b);
            run_op(d, b, ($urandom_range(3) == 0));
        end

        wait_idle();
        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
